// File: rtl/fifo_byte_unpacker_rd.sv
// Read-side FIFO consumer: strobes bytes out of an 8-bit FIFO and packs them into BYTES-wide words on a valid/ready stream.
// Optional FIFO_RD_BIG_ENDIAN_EN places the first byte in the most significant lane.
module fifo_byte_unpacker_rd #(
  parameter  int BYTES = 4,
  localparam int CNT_W = $clog2(BYTES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty,
  output logic               fifo_rd,
  input  logic [7:0]         fifo_rd_data,
  input  logic               flush,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [8*BYTES-1:0] m_data,
  output logic [CNT_W-1:0]   m_nbytes,
  output logic               busy
);

  typedef enum logic [1:0] {S_FILL, S_FULL, S_FLUSH} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        iss_cnt, cap_cnt;
  logic                    rd_q, flush_pend;
  logic [BYTES-1:0][7:0]   asm_reg;
  logic                    out_free, xfer, flush_done;

  assign out_free = !m_valid || m_ready;

  // A transfer never coincides with a strobe or capture: S_FULL implies all
  // bytes landed, and S_FLUSH only transfers once nothing is in flight.
  always_comb begin
    xfer       = 1'b0;
    flush_done = 1'b0;
    case (state)
      S_FULL:  xfer = out_free;
      S_FLUSH: if (!rd_q) begin
        if (cap_cnt == '0) begin
          flush_done = 1'b1;
        end else if (out_free) begin
          xfer       = 1'b1;
          flush_done = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign fifo_rd = (state == S_FILL) && !fifo_empty && (iss_cnt < CNT_W'(BYTES))
                   && !flush_pend && !rst;

  assign busy = (iss_cnt != '0) || (cap_cnt != '0) || m_valid || flush_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FILL;
      iss_cnt    <= '0;
      cap_cnt    <= '0;
      rd_q       <= 1'b0;
      flush_pend <= 1'b0;
      asm_reg    <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_nbytes   <= '0;
    end else begin
      rd_q <= fifo_rd;

      if (xfer) begin
        m_data   <= asm_reg;
        m_nbytes <= cap_cnt;
        m_valid  <= 1'b1;
        asm_reg  <= '0;
        iss_cnt  <= '0;
        cap_cnt  <= '0;
      end else begin
        if (m_ready) m_valid <= 1'b0;
        if (fifo_rd) iss_cnt <= iss_cnt + 1'b1;
        if (rd_q) begin
          cap_cnt <= cap_cnt + 1'b1;
          for (int k = 0; k < BYTES; k++) begin
            if (cap_cnt == CNT_W'(k)) begin
`ifdef FIFO_RD_BIG_ENDIAN_EN
              asm_reg[BYTES-1-k] <= fifo_rd_data;
`else
              asm_reg[k] <= fifo_rd_data;
`endif
            end
          end
        end
      end

      // Clearing wins over a new request so a flush landing on the clear cycle is absorbed.
      if (flush_done)  flush_pend <= 1'b0;
      else if (flush)  flush_pend <= 1'b1;

      case (state)
        S_FILL: begin
          if (rd_q && cap_cnt == CNT_W'(BYTES - 1)) state <= S_FULL;
          else if (flush_pend)                       state <= S_FLUSH;
        end
        S_FULL:  if (xfer) state <= S_FILL;
        S_FLUSH: if (xfer || flush_done) state <= S_FILL;
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_byte_unpacker_rd.sv
// Bench for fifo_byte_unpacker_rd: FIFO model, byte-stream scoreboard, directed cases and random traffic.
module tb_fifo_byte_unpacker_rd;
  localparam int BYTES = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             fifo_empty = 1'b1;
  logic             fifo_rd;
  logic [7:0]       fifo_rd_data = 8'h00;
  logic             flush = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [31:0]      m_data;
  logic [CNT_W-1:0] m_nbytes;
  logic             busy;

  fifo_byte_unpacker_rd #(.BYTES(BYTES)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .fifo_rd_data(fifo_rd_data), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_nbytes(m_nbytes), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [31:0] data; int n; } word_t;
  logic [7:0] fq[$];    // FIFO contents
  logic [7:0] wq[$];    // bytes waiting to be written into the FIFO
  logic [7:0] pend[$];  // bytes popped but not yet forming a word
  word_t      exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] b0, b1, b2, b3);
`ifdef FIFO_RD_BIG_ENDIAN_EN
    return {b0, b1, b2, b3};
`else
    return {b3, b2, b1, b0};
`endif
  endfunction

  task automatic emit();
    word_t w;
    w.data = '0;
    w.n    = pend.size();
    for (int k = 0; k < pend.size(); k++) begin
`ifdef FIFO_RD_BIG_ENDIAN_EN
      w.data[8*(BYTES-1-k) +: 8] = pend[k];
`else
      w.data[8*k +: 8] = pend[k];
`endif
    end
    exp_q.push_back(w);
    pend.delete();
  endtask

  // FIFO with registered empty flag, plus the stream-level reference model:
  // popped bytes group into words of BYTES; a flush closes whatever is pending.
  always @(posedge clk) begin : fifo_model
    logic [7:0] b;
    bit popped;
    popped = 1'b0;
    b = 8'h00;
    if (fifo_rd) begin
      chk("fifo_rd_not_empty", fq.size() != 0, 1);
      if (fq.size() != 0) begin
        b = fq.pop_front();
        popped = 1'b1;
        fifo_rd_data <= b;
      end
    end
    if (wq.size() != 0) fq.push_back(wq.pop_front());
    fifo_empty <= (fq.size() == 0);
    if (rst) begin
      pend.delete();
      exp_q.delete();
    end else begin
      if (m_valid && m_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (popped) begin
        pend.push_back(b);
        if (pend.size() == BYTES) emit();
      end
      if (flush && pend.size() != 0) emit();
    end
  end

  always @(negedge clk) begin
    if (!rst && m_valid) begin
      if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
      else begin
        chk("sb_m_data", m_data, exp_q[0].data);
        chk("sb_m_nbytes", m_nbytes, exp_q[0].n);
      end
    end
  end

  task automatic wait_valid(input string name, input int lim);
    int n;
    n = 0;
    @(negedge clk);
    while (!m_valid && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(name, m_valid, 1);
  endtask

  task automatic wait_rd(input string name, input int lim);
    int n;
    n = 0;
    @(negedge clk);
    while (!fifo_rd && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(name, fifo_rd, 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || fq.size() != 0 || wq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, 0);
  endtask

  initial begin
    int n;
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_nbytes", m_nbytes, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Preloaded 4 bytes -> 4 back-to-back strobes and one word
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
    wait_rd("t1_rd_start", 10);
    n = 0;
    while (fifo_rd && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("t1_rd_burst_len", n, 4);
    wait_valid("t1_valid", 20);
    chk("t1_m_data", m_data, mk(8'h11, 8'h22, 8'h33, 8'h44));
    chk("t1_m_nbytes", m_nbytes, 4);
    @(negedge clk);
    chk("t1_valid_one_cycle", m_valid, 0);
    chk("t1_rd_idle", fifo_rd, 0);
    wait_idle("t1_idle");

    // Backpressure: 12 bytes available, only two words may be pulled in
    @(posedge clk); #1 m_ready = 1'b0;
    for (int i = 1; i <= 12; i++) fq.push_back(8'(i));
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (fifo_rd) n++;
    end
    chk("t2_reads_while_stalled", n, 8);
    chk("t2_hold_valid", m_valid, 1);
    chk("t2_hold_data", m_data, mk(8'h01, 8'h02, 8'h03, 8'h04));
    @(posedge clk); #1 m_ready = 1'b1;
    @(negedge clk);
    chk("t2_first_still", m_data, mk(8'h01, 8'h02, 8'h03, 8'h04));
    @(negedge clk);
    chk("t2_second_valid", m_valid, 1);
    chk("t2_second_data", m_data, mk(8'h05, 8'h06, 8'h07, 8'h08));
    wait_idle("t2_idle");

    // Partial word via flush
    @(posedge clk); #1;
    fq.push_back(8'hAA); fq.push_back(8'hBB); fq.push_back(8'hCC);
    repeat (8) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    wait_valid("t3_valid", 10);
    chk("t3_m_data", m_data, mk(8'hAA, 8'hBB, 8'hCC, 8'h00));
    chk("t3_m_nbytes", m_nbytes, 3);
    wait_idle("t3_idle");

    // Flush the cycle after the last of two strobes: in-flight byte must be kept
    @(posedge clk); #1;
    fq.push_back(8'h5A); fq.push_back(8'hA5);
    wait_rd("t4_rd_start", 10);
    @(posedge clk); #1;
    chk("t4_second_strobe", fifo_rd, 1);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    wait_valid("t4_valid", 10);
    chk("t4_m_nbytes", m_nbytes, 2);
    chk("t4_m_data", m_data, mk(8'h5A, 8'hA5, 8'h00, 8'h00));
    wait_idle("t4_idle");

    // Flush with nothing buffered
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_output", m_valid, 0);
      if (!busy) break;
    end
    chk("t5_busy_clears", busy, 0);

    // Reset with two bytes captured and one in flight
    @(posedge clk); #1;
    fq.push_back(8'hD1); fq.push_back(8'hD2); fq.push_back(8'hD3);
    wait_rd("t6_rd_start", 10);
    @(posedge clk); @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_fifo_rd", fifo_rd, 0);
    chk("t6_m_valid", m_valid, 0);
    chk("t6_m_data", m_data, 0);
    chk("t6_m_nbytes", m_nbytes, 0);
    chk("t6_busy", busy, 0);
    @(posedge clk); #1;
    fq.push_back(8'h71); fq.push_back(8'h72); fq.push_back(8'h73); fq.push_back(8'h74);
    wait_valid("t6_valid", 20);
    chk("t6_clean_word", m_data, mk(8'h71, 8'h72, 8'h73, 8'h74));
    chk("t6_clean_nbytes", m_nbytes, 4);
    wait_idle("t6_idle");

    // Random traffic, backpressure, flushes and occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 2) == 0) wq.push_back(8'($urandom));
      m_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 40) == 0);
      rst     = ($urandom_range(0, 400) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; m_ready = 1'b1;
    n = 0;
    while ((wq.size() != 0 || fq.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    wait_idle("rand_drain_idle");
    chk("rand_all_words_seen", exp_q.size(), 0);
    chk("rand_no_pending_bytes", pend.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
